// File: rtl/secuenciador_hold_registros_if.sv
// ---------------------------------------------------------------------------
// secuenciador_hold_registros_if
// Signal bundle between the RTC hold sequencer, the RTC bus controller and
// the hora/fecha/timer shadow register bank.
//
//   iniciar        single-cycle start-sweep pulse
//   modo_conf      one-hot group under user configuration (0 = normal mode)
//   dato_valido    bus controller has data for rd_addr this cycle
//   rd_req         read request towards the bus controller
//   rd_addr        address of the register being read
//   hold_n         per-register hold, active low (0 = register loads)
//   ocupado        sweep in progress
//   fin            one-cycle pulse when a sweep completes
//   error_timeout  sticky: a read timed out during the last sweep
//
// master: the sequencer itself.  slave: whoever drives the control/bus side.
// ---------------------------------------------------------------------------
interface secuenciador_hold_registros_if #(
    parameter int NUM_REGS   = 9,
    parameter int NUM_GRUPOS = 3,
    parameter int ADDR_W     = 4
);
    logic                  iniciar;
    logic [NUM_GRUPOS-1:0] modo_conf;
    logic                  dato_valido;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic [NUM_REGS-1:0]   hold_n;
    logic                  ocupado;
    logic                  fin;
    logic                  error_timeout;

    modport master (
        input  iniciar,
        input  modo_conf,
        input  dato_valido,
        output rd_req,
        output rd_addr,
        output hold_n,
        output ocupado,
        output fin,
        output error_timeout
    );

    modport slave (
        output iniciar,
        output modo_conf,
        output dato_valido,
        input  rd_req,
        input  rd_addr,
        input  hold_n,
        input  ocupado,
        input  fin,
        input  error_timeout
    );
endinterface

// File: rtl/secuenciador_hold_registros.sv
// ---------------------------------------------------------------------------
// secuenciador_hold_registros
// On a start pulse, sweeps every RTC shadow register that is not owned by the
// configuration group latched at start. Each register is read through the
// bus controller and, once data is valid, its active-low hold is strobed for
// one cycle so the register reloads. Registers of the live-configured group
// keep hold low permanently so the user can write them.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    secuenciador_hold_registros_if.master (see interface file)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module secuenciador_hold_registros #(
    parameter int NUM_REGS       = 9,
    parameter int NUM_GRUPOS     = 3,
    parameter int REGS_POR_GRUPO = 3,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic clk,
    input  logic reset,
    secuenciador_hold_registros_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [1:0] {IDLE, REQ, CAP, FIN} estado_t;

    estado_t               estado_q, estado_d;
    logic [ADDR_W-1:0]     indice_q, indice_d;
    logic [NUM_GRUPOS-1:0] saltar_q, saltar_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [NUM_REGS-1:0]   hold_n_q, hold_n_d;
    logic                  ocupado_q, ocupado_d;
    logic                  fin_q, fin_d;

    logic                  conf_legal;
    logic [ADDR_W:0]       busq_ini;
    logic [ADDR_W:0]       busq_sig;
    logic [NUM_REGS-1:0]   hold_conf_n;
    logic [NUM_REGS-1:0]   strobe_n;

    // Expands a group vector into the set of registers those groups own.
    function automatic logic [NUM_REGS-1:0] mascara_grupo(input logic [NUM_GRUPOS-1:0] grupos);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m[i] = grupos[i / REGS_POR_GRUPO];
        end
        return m;
    endfunction

    // Lowest set bit of candidatos at or above desde; MSB of result = found.
    // Scanning downwards lets the last hit be the lowest index.
    function automatic logic [ADDR_W:0] buscar(input logic [NUM_REGS-1:0] candidatos, input int desde);
        logic [ADDR_W:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (candidatos[i] && (i >= desde)) begin
                r = {1'b1, ADDR_W'(i)};
            end
        end
        return r;
    endfunction

    // modo_conf is legal when at most one bit is set.
    assign conf_legal = ((bus.modo_conf & (bus.modo_conf - NUM_GRUPOS'(1))) == '0);

    // State register plus the registered copies of every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= IDLE;
            indice_q  <= '0;
            saltar_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            hold_n_q  <= '1;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            indice_q  <= indice_d;
            saltar_q  <= saltar_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            hold_n_q  <= hold_n_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
        end
    end

    // Next-state logic: start acceptance, read wait with timeout, and the
    // next-set-bit walk over the registers not owned by the latched group.
    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        saltar_d = saltar_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        busq_ini = buscar(~mascara_grupo(bus.modo_conf), 0);
        busq_sig = buscar(~mascara_grupo(saltar_q), int'(indice_q) + 1);

        unique case (estado_q)
            IDLE: begin
                if (bus.iniciar && conf_legal) begin
                    saltar_d = bus.modo_conf;
                    if (busq_ini[ADDR_W]) begin
                        estado_d = REQ;
                        indice_d = busq_ini[ADDR_W-1:0];
                        cnt_d    = '0;
                        err_d    = 1'b0;
                    end else begin
                        estado_d = FIN;
                    end
                end
            end
            REQ: begin
                // Valid data on the last allowed cycle still wins over timeout.
                if (bus.dato_valido) begin
                    estado_d = CAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
                    err_d = 1'b1;
                    if (busq_sig[ADDR_W]) begin
                        indice_d = busq_sig[ADDR_W-1:0];
                        cnt_d    = '0;
                    end else begin
                        estado_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAP: begin
                if (busq_sig[ADDR_W]) begin
                    estado_d = REQ;
                    indice_d = busq_sig[ADDR_W-1:0];
                    cnt_d    = '0;
                end else begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Output logic, computed from the next state so the registered outputs
    // line up with the state they describe. Configuration enables and the
    // sweep strobe are both active low, so they combine with AND; an illegal
    // modo_conf forces every hold low.
    always_comb begin
        hold_conf_n = conf_legal ? ~mascara_grupo(bus.modo_conf) : '0;
        strobe_n    = '1;
        if (estado_d == CAP) begin
            strobe_n = ~(NUM_REGS'(1) << indice_d);
        end
        rd_req_d  = (estado_d == REQ);
        rd_addr_d = indice_d;
        hold_n_d  = hold_conf_n & strobe_n;
        ocupado_d = (estado_d != IDLE);
        fin_d     = (estado_d == FIN);
    end

    assign bus.rd_req        = rd_req_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.hold_n        = hold_n_q;
    assign bus.ocupado       = ocupado_q;
    assign bus.fin           = fin_q;
    assign bus.error_timeout = err_q;

endmodule

// File: tb/tb_secuenciador_hold_registros.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_hold_registros
// Randomised scoreboard bench for secuenciador_hold_registros. The main
// process issues sweeps and queues the expected read addresses and fin; a
// responder answers reads after a random delay (or never, for addresses
// marked as silent) and queues the strobe it should cause; a monitor pops
// and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_secuenciador_hold_registros;
    localparam int NUM_REGS       = 9;
    localparam int NUM_GRUPOS     = 3;
    localparam int REGS_POR_GRUPO = 3;
    localparam int ADDR_W         = 4;
    localparam int TIMEOUT_CICLOS = 16;

    typedef struct {
        int unsigned due;
        int          reg_i;
    } strobe_t;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    int unsigned         cyc = 0;
    logic [2:0]          conf_prev = '0;
    logic                reset_prev = 1'b1;
    logic [NUM_REGS-1:0] no_resp = '0;

    int      q_addr[$];
    int      q_dur[$];
    int      q_fin[$];
    strobe_t q_strobe[$];

    secuenciador_hold_registros_if #(
        .NUM_REGS  (NUM_REGS),
        .NUM_GRUPOS(NUM_GRUPOS),
        .ADDR_W    (ADDR_W)
    ) bus_if ();

    secuenciador_hold_registros #(
        .NUM_REGS      (NUM_REGS),
        .NUM_GRUPOS    (NUM_GRUPOS),
        .REGS_POR_GRUPO(REGS_POR_GRUPO),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.master)
    );

    always #5 clk = ~clk;

    // Cycle counter and the inputs as the DUT saw them at the last edge.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        conf_prev  <= bus_if.modo_conf;
        reset_prev <= reset;
    end

    // Registers held low by configuration; an illegal encoding holds all.
    function automatic logic [NUM_REGS-1:0] expand(input logic [2:0] conf);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if ($countones(conf) > 1) return '1;
        for (int r = 0; r < NUM_REGS; r++) m[r] = conf[r / REGS_POR_GRUPO];
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Responder: answers each new read after 0..3 cycles unless silenced.
    initial begin
        int   wait_cnt;
        int   delay;
        bit   mute;
        logic prev_req;
        logic [ADDR_W-1:0] prev_addr;
        wait_cnt  = 0;
        delay     = 0;
        mute      = 1'b0;
        prev_req  = 1'b0;
        prev_addr = '0;
        bus_if.dato_valido = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.rd_req === 1'b1) begin
                if (!prev_req || bus_if.rd_addr != prev_addr) begin
                    mute     = no_resp[bus_if.rd_addr];
                    delay    = $urandom_range(0, 3);
                    wait_cnt = 0;
                    q_dur.push_back(mute ? TIMEOUT_CICLOS : delay + 1);
                end
                if (!mute && wait_cnt == delay) begin
                    bus_if.dato_valido = 1'b1;
                    q_strobe.push_back('{due: cyc + 1, reg_i: int'(bus_if.rd_addr)});
                end else begin
                    bus_if.dato_valido = 1'b0;
                end
                wait_cnt++;
            end else begin
                // Noise outside a read must be ignored by the DUT.
                bus_if.dato_valido = ($urandom_range(0, 3) == 0);
            end
            prev_req  = (bus_if.rd_req === 1'b1);
            prev_addr = bus_if.rd_addr;
        end
    end

    // Monitor: compares requests, durations, strobes, holds and fin.
    initial begin
        logic                prev_req;
        logic [ADDR_W-1:0]   prev_addr;
        int                  dur;
        logic                fin_prev;
        logic                req_next;
        logic [NUM_REGS-1:0] conf_mask;
        logic [NUM_REGS-1:0] strobe_bits;
        strobe_t             s;
        prev_req  = 1'b0;
        prev_addr = '0;
        dur       = 0;
        fin_prev  = 1'b0;
        req_next  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_prev || cyc < 2) begin
                prev_req = 1'b0;
                dur      = 0;
                fin_prev = 1'b0;
                req_next = 1'b0;
                continue;
            end
            conf_mask   = expand(conf_prev);
            strobe_bits = ~bus_if.hold_n & ~conf_mask;
            checkOutput("hold_conf", 32'(bus_if.hold_n & conf_mask), 0);

            if (req_next) checkOutput("req_after_cap", bus_if.rd_req, 1);
            req_next = 1'b0;

            if (q_strobe.size() > 0 && q_strobe[0].due == cyc) begin
                s = q_strobe.pop_front();
                checkOutput("cap_rd_req_low", bus_if.rd_req, 0);
                if (conf_mask[s.reg_i]) checkOutput("strobe_masked", 32'(strobe_bits), 0);
                else                    checkOutput("strobe_reg", 32'(strobe_bits), 32'(1) << s.reg_i);
                req_next = (q_addr.size() != 0);
            end else begin
                checkOutput("strobe_unexpected", 32'(strobe_bits), 0);
            end

            if (prev_req && (!bus_if.rd_req || bus_if.rd_addr != prev_addr)) begin
                if (q_dur.size() > 0) checkOutput("req_duration", dur, q_dur.pop_front());
            end
            if (bus_if.rd_req && (!prev_req || bus_if.rd_addr != prev_addr)) begin
                checkOutput("req_pending", q_addr.size() != 0, 1);
                if (q_addr.size() != 0) checkOutput("req_addr", bus_if.rd_addr, q_addr.pop_front());
                dur = 1;
            end else if (bus_if.rd_req) begin
                dur++;
            end
            prev_req  = bus_if.rd_req;
            prev_addr = bus_if.rd_addr;

            if (fin_prev) checkOutput("ocupado_after_fin", bus_if.ocupado, 0);
            if (bus_if.fin) begin
                checkOutput("fin_expected", q_fin.size() != 0, 1);
                if (q_fin.size() != 0) void'(q_fin.pop_front());
                checkOutput("ocupado_at_fin", bus_if.ocupado, 1);
                checkOutput("fin_after_reads", q_addr.size() + q_strobe.size(), 0);
            end
            fin_prev = bus_if.fin;
        end
    end

    // Queues the sweep the reference model expects for a latched conf.
    task automatic pushSweep(input logic [2:0] conf, output int first, output bit exp_err);
        first   = -1;
        exp_err = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!conf[r / REGS_POR_GRUPO]) begin
                q_addr.push_back(r);
                if (first < 0) first = r;
                if (no_resp[r]) exp_err = 1'b1;
            end
        end
        q_fin.push_back(1);
    endtask

    task automatic waitSweepEnd();
        int budget;
        budget = 0;
        while (q_fin.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("sweep_done_in_time", q_fin.size(), 0);
        repeat (2) @(negedge clk);
        checkOutput("idle_ocupado", bus_if.ocupado, 0);
        checkOutput("leftover_expect", q_addr.size() + q_strobe.size() + q_dur.size(), 0);
    endtask

    task automatic waitAddr(input int addr);
        int budget;
        budget = 0;
        while (!(bus_if.rd_req === 1'b1 && bus_if.rd_addr == addr) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("reached_addr", bus_if.rd_addr, addr);
    endtask

    task automatic startSweep(input logic [2:0] conf, input logic [NUM_REGS-1:0] nresp, output bit exp_err);
        int first;
        @(negedge clk);
        bus_if.modo_conf = conf;
        no_resp          = nresp;
        @(negedge clk);
        pushSweep(conf, first, exp_err);
        bus_if.iniciar = 1'b1;
        @(negedge clk);
        bus_if.iniciar = 1'b0;
        checkOutput("start_rd_req", bus_if.rd_req, 1);
        checkOutput("start_addr", bus_if.rd_addr, first);
        checkOutput("start_ocupado", bus_if.ocupado, 1);
        checkOutput("start_err_clear", bus_if.error_timeout, 0);
    endtask

    task automatic applyStimulus(input logic [2:0] conf, input logic [NUM_REGS-1:0] nresp);
        bit exp_err;
        startSweep(conf, nresp, exp_err);
        waitSweepEnd();
        checkOutput("end_err", bus_if.error_timeout, exp_err);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit                  exp_err;
        logic [2:0]          conf;
        logic [NUM_REGS-1:0] nresp;
        logic [2:0]          legal_confs [4];
        legal_confs[0] = 3'b000;
        legal_confs[1] = 3'b001;
        legal_confs[2] = 3'b010;
        legal_confs[3] = 3'b100;

        reset            = 1'b1;
        bus_if.iniciar   = 1'b0;
        bus_if.modo_conf = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hold_n", bus_if.hold_n, 9'h1FF);
        checkOutput("reset_rd_req", bus_if.rd_req, 0);
        checkOutput("reset_rd_addr", bus_if.rd_addr, 0);
        checkOutput("reset_ocupado", bus_if.ocupado, 0);
        checkOutput("reset_fin", bus_if.fin, 0);
        checkOutput("reset_err", bus_if.error_timeout, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] normal sweeps");
        applyStimulus(3'b000, '0);
        applyStimulus(3'b000, '0);

        $display("[TB] group 0 under configuration");
        applyStimulus(3'b001, '0);

        $display("[TB] timeout on address 4");
        applyStimulus(3'b000, 9'h010);
        repeat (5) @(negedge clk);
        checkOutput("err_sticky", bus_if.error_timeout, 1);
        applyStimulus(3'b000, '0);

        $display("[TB] illegal modo_conf");
        @(negedge clk);
        bus_if.modo_conf = 3'b101;
        repeat (2) @(negedge clk);
        checkOutput("illegal_hold", bus_if.hold_n, 0);
        bus_if.iniciar = 1'b1;
        @(negedge clk);
        bus_if.iniciar = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("illegal_rd_req", bus_if.rd_req, 0);
        checkOutput("illegal_ocupado", bus_if.ocupado, 0);
        bus_if.modo_conf = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("legal_hold_back", bus_if.hold_n, 9'h1FF);

        $display("[TB] reset during read of address 6");
        startSweep(3'b000, 9'h040, exp_err);
        waitAddr(6);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_rd_req", bus_if.rd_req, 0);
        checkOutput("rst_mid_hold_n", bus_if.hold_n, 9'h1FF);
        checkOutput("rst_mid_ocupado", bus_if.ocupado, 0);
        checkOutput("rst_mid_err", bus_if.error_timeout, 0);
        q_addr.delete();
        q_strobe.delete();
        q_dur.delete();
        q_fin.delete();
        @(negedge clk);
        reset   = 1'b0;
        no_resp = '0;
        repeat (4) @(negedge clk);
        checkOutput("rst_no_restart", bus_if.ocupado, 0);
        applyStimulus(3'b000, '0);

        $display("[TB] mid-sweep iniciar and configuration change");
        startSweep(3'b000, '0, exp_err);
        waitAddr(3);
        bus_if.iniciar = 1'b1;
        @(negedge clk);
        bus_if.iniciar   = 1'b0;
        bus_if.modo_conf = 3'b100;
        @(negedge clk);
        checkOutput("conf_change_hold", 32'(bus_if.hold_n[8:6]), 0);
        waitSweepEnd();
        bus_if.modo_conf = 3'b000;
        repeat (2) @(negedge clk);

        $display("[TB] random sweeps");
        for (int k = 0; k < 8; k++) begin
            conf  = legal_confs[$urandom_range(0, 3)];
            nresp = ($urandom_range(0, 2) == 0) ? (NUM_REGS'(1) << $urandom_range(0, NUM_REGS - 1)) : '0;
            applyStimulus(conf, nresp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
